// File: rtl/gppcu_sb_pkg.sv
// Shared helpers for the GPPCU register scoreboard: index width sizing,
// counter ceiling and writeback hit counting.
package gppcu_sb_pkg;

  function automatic int unsigned bit_fit(input int unsigned v);
    int unsigned n;
    n = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gppcu_sb_entry.sv
// One scoreboard entry: pending-write counter for a single register with
// same-cycle increment/retire, flush and underflow detection.
module gppcu_sb_entry #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned HW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [HW-1:0]    wb_hits,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             underflow
);

  // Wide enough to hold cnt+1 and any hit count without wrapping.
  localparam int unsigned SW = ((CNT_W + 1 > HW) ? CNT_W + 1 : HW) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum, hits;

  always_comb begin
    sum       = SW'(cnt_q) + SW'(inc);
    hits      = SW'(wb_hits);
    underflow = 1'b0;
    cnt_d     = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (sum < hits) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end else begin
      cnt_d = CNT_W'(sum - hits);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/gppcu_scoreboard.sv
// GPPCU issue-stage scoreboard: per-register pending-write counters, RAW/WAW
// hazard detection with optional writeback bypass, stall statistic and error flag.
module gppcu_scoreboard
  import gppcu_sb_pkg::*;
#(
  parameter int unsigned NUMREG   = 32,
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned RBW     = bit_fit(NUMREG - 1)
) (
  input  logic                    iACLK,
  input  logic                    iRST,
  input  logic                    iISSUE_VALID,
  input  logic [RBW-1:0]          iREGD,
  input  logic                    iVALID_REGD,
  input  logic [NUM_SRC*RBW-1:0]  iREGS,
  input  logic [NUM_SRC-1:0]      iVALID_REGS,
  output logic                    oENABLED,
  input  logic [NUM_WB*RBW-1:0]   iWB_REG,
  input  logic [NUM_WB-1:0]       iWB_VALID,
  input  logic                    iFLUSH,
  output logic [NUMREG-1:0]       oBUSY,
  output logic                    oIDLE,
  output logic [31:0]             oSTALL_CNT,
  output logic                    oERR
);

  localparam int unsigned HW = bit_fit(NUM_WB);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0]  cnt     [NUMREG];
  logic [HW-1:0]     wb_hits [NUMREG];
  logic [NUMREG-1:0] inc, busy, uflow;
  logic              fire, raw, waw, enabled;
  logic [RBW-1:0]    src;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;

  assign fire = iISSUE_VALID & enabled & iVALID_REGD;

  for (genvar r = 0; r < NUMREG; r++) begin : g_reg
    logic [NUM_WB-1:0] hit_vec;

    always_comb begin
      hit_vec = '0;
      for (int unsigned p = 0; p < NUM_WB; p++) begin
        hit_vec[p] = iWB_VALID[p] & (iWB_REG[p*RBW +: RBW] == RBW'(r));
      end
    end

    assign wb_hits[r] = HW'(popcount(32'(hit_vec)));
    assign inc[r]     = fire & (iREGD == RBW'(r));

    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign cnt[r]   = '0;
      assign busy[r]  = 1'b0;
      assign uflow[r] = 1'b0;
    end else begin : g_entry
      gppcu_sb_entry #(
        .CNT_W (CNT_W),
        .HW    (HW)
      ) u_entry (
        .clk       (iACLK),
        .rst       (iRST),
        .inc       (inc[r]),
        .wb_hits   (wb_hits[r]),
        .flush     (iFLUSH),
        .cnt       (cnt[r]),
        .busy      (busy[r]),
        .underflow (uflow[r])
      );
    end
  end

  // A source is safe under bypass once every outstanding write retires now.
  always_comb begin
    raw = 1'b0;
    src = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (iVALID_REGS[k]) begin
        src = iREGS[k*RBW +: RBW];
        if (cnt[src] != '0 &&
            !(BYPASS != 0 && 32'(cnt[src]) <= 32'(wb_hits[src]))) begin
          raw = 1'b1;
        end
      end
    end
    waw     = iVALID_REGD & (cnt[iREGD] == CMAX) & (wb_hits[iREGD] == '0);
    enabled = ~(raw | waw);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (iISSUE_VALID && !enabled && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    err_d = err_q | (|uflow);
  end

  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign oENABLED   = enabled;
  assign oBUSY      = busy;
  assign oIDLE      = ~(|busy);
  assign oSTALL_CNT = stall_cnt_q;
  assign oERR       = err_q;

endmodule
